axis_kernel_window_3x3: RTL and testbench

- Upstream neighbour of the 3x3 row/column sorting stage.
- Accepts a raster-order AXI4-Stream pixel stream and keeps two line buffers plus a 3x3 shift window.
- Emits a complete 3x3 pixel kernel, in the same [row][col] array form the sorter consumes, for every interior pixel position.
- Provides valid/ready backpressure toward the downstream pipeline.

---
 rtl/axis_kernel_window_3x3.sv | 191 +++++++++++++++++++
 tb/tb_axis_kernel_window_3x3.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_kernel_window_3x3.sv
// -----------------------------------------------------------------------------
// axis_kernel_window_3x3
//
// Purpose:
//   Turns a raster-order AXI4-Stream pixel stream into a stream of 3x3 pixel
//   kernels, one per interior pixel position, for the row/column sorting
//   stage downstream. Two line buffers hold the previous two image lines and
//   a 3x3 shift window collects the columns as pixels arrive.
//
// Ports:
//   i_clk                 clock
//   i_reset               synchronous active-high reset
//   s_axis_tdata          input pixel
//   s_axis_tvalid         input pixel valid
//   s_axis_tready         input ready (blocked while a window is pending)
//   s_axis_tuser          start of frame, marks pixel (0,0)
//   s_axis_tlast          end of line, checked against the column counter
//   o_image_kernel_buffer window [row][col], [0][*] oldest row, [*][0] leftmost
//   o_kernel_valid        window valid
//   i_kernel_ready        downstream accepts the window
//   o_line_err            sticky tlast-position error
// -----------------------------------------------------------------------------
module axis_kernel_window_3x3 #(
  parameter int DATA_WIDTH  = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480
) (
  input  logic                                i_clk,
  input  logic                                i_reset,
  input  logic [DATA_WIDTH-1:0]               s_axis_tdata,
  input  logic                                s_axis_tvalid,
  output logic                                s_axis_tready,
  input  logic                                s_axis_tuser,
  input  logic                                s_axis_tlast,
  output logic [0:2][0:2][DATA_WIDTH-1:0]     o_image_kernel_buffer,
  output logic                                o_kernel_valid,
  input  logic                                i_kernel_ready,
  output logic                                o_line_err
);

  localparam int ColW = $clog2(IMG_WIDTH);
  localparam int RowW = $clog2(IMG_HEIGHT);

  localparam logic [ColW-1:0] ColLast = ColW'(IMG_WIDTH - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(IMG_HEIGHT - 1);
  localparam logic [ColW-1:0] ColTwo  = ColW'(2);
  localparam logic [RowW-1:0] RowTwo  = RowW'(2);

  // The window geometry below is hard-wired to 3x3, so any other kernel
  // size must stop elaboration rather than silently produce wrong kernels.
  if (KERNEL_SIZE != 3) begin : gen_kernelSizeCheck
    $error("axis_kernel_window_3x3 supports KERNEL_SIZE == 3 only");
  end

  typedef enum logic {
    WAIT_SOF,
    ACTIVE
  } state_t;

  state_t                             state_q, state_d;
  logic [ColW-1:0]                    col_q, col_d;
  logic [RowW-1:0]                    row_q, row_d;
  logic [0:2][0:2][DATA_WIDTH-1:0]    window_q, window_d;
  logic                               valid_q, valid_d;
  logic                               lineErr_q, lineErr_d;

  logic [DATA_WIDTH-1:0]              lineBuf0 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0]              lineBuf1 [IMG_WIDTH];

  logic                               beatFire;
  logic                               pixelFire;
  logic [ColW-1:0]                    pixCol;
  logic [RowW-1:0]                    pixRow;
  logic [0:2][DATA_WIDTH-1:0]         newColumn;
  logic                               emitWindow;
  logic                               tlastBad;

  // The single output register is the only storage between us and the
  // sorter, so input is accepted only when that register is free or is
  // being emptied this cycle. Holding ready low during reset keeps the
  // source from believing a beat was taken while state is being cleared.
  assign s_axis_tready = !i_reset && (!valid_q || i_kernel_ready);
  assign beatFire      = s_axis_tvalid && s_axis_tready;

  // A beat carrying tuser always starts a frame at (0,0), whether we were
  // waiting for it or it interrupts a frame in progress. Beats before the
  // first start of frame are swallowed.
  assign pixelFire = beatFire && ((state_q == ACTIVE) || s_axis_tuser);
  assign pixCol    = s_axis_tuser ? '0 : col_q;
  assign pixRow    = s_axis_tuser ? '0 : row_q;

  // The incoming column stacks the pixel from two lines up, the pixel from
  // the line above and the new pixel, oldest on top.
  assign newColumn[0] = lineBuf1[pixCol];
  assign newColumn[1] = lineBuf0[pixCol];
  assign newColumn[2] = s_axis_tdata;

  // Only positions with two complete lines and two complete columns behind
  // them produce a kernel; earlier columns of the window still hold pixels
  // from the end of the previous line and must never be emitted.
  assign emitWindow = pixelFire && (pixRow >= RowTwo) && (pixCol >= ColTwo);

  // tlast must be high exactly on the last column of every line.
  assign tlastBad = (pixCol == ColLast) != s_axis_tlast;

  // Next-state logic for the frame position, the shift window, the output
  // valid flag and the sticky line error. The position counters follow the
  // configured width only; tlast is checked but never steers them.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    window_d  = window_q;
    valid_d   = valid_q;
    lineErr_d = lineErr_q;

    if (valid_q && i_kernel_ready) begin
      valid_d = 1'b0;
    end

    if (pixelFire) begin
      for (int r = 0; r < 3; r++) begin
        window_d[r][0] = window_q[r][1];
        window_d[r][1] = window_q[r][2];
        window_d[r][2] = newColumn[r];
      end

      if (s_axis_tuser) begin
        lineErr_d = 1'b0;
      end
      if (tlastBad) begin
        lineErr_d = 1'b1;
      end

      if (emitWindow) begin
        valid_d = 1'b1;
      end

      if (pixCol == ColLast) begin
        col_d = '0;
        if (pixRow == RowLast) begin
          row_d   = '0;
          state_d = WAIT_SOF;
        end else begin
          row_d   = pixRow + RowW'(1);
          state_d = ACTIVE;
        end
      end else begin
        col_d   = pixCol + ColW'(1);
        row_d   = pixRow;
        state_d = ACTIVE;
      end
    end
  end

  // Control and window registers. Reset drops any pending kernel; the
  // line buffers are left alone because the first two lines of the next
  // frame overwrite them before any kernel can be formed.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= WAIT_SOF;
      col_q     <= '0;
      row_q     <= '0;
      window_q  <= '0;
      valid_q   <= 1'b0;
      lineErr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      window_q  <= window_d;
      valid_q   <= valid_d;
      lineErr_q <= lineErr_d;
    end
  end

  // Line buffers: each accepted pixel pushes the column down one line,
  // so lineBuf0 holds the line above and lineBuf1 the line two above.
  always_ff @(posedge i_clk) begin
    if (pixelFire) begin
      lineBuf1[pixCol] <= lineBuf0[pixCol];
      lineBuf0[pixCol] <= s_axis_tdata;
    end
  end

  assign o_image_kernel_buffer = window_q;
  assign o_kernel_valid        = valid_q;
  assign o_line_err            = lineErr_q;

endmodule

// File: tb/tb_axis_kernel_window_3x3.sv
// -----------------------------------------------------------------------------
// tb_axis_kernel_window_3x3
//
// Purpose:
//   Self-checking bench for axis_kernel_window_3x3 on a 5x4 image. A
//   reference model keeps the frame as a plain image array, pushes the
//   expected kernel for every interior pixel onto a scoreboard queue, and a
//   monitor pops and compares each kernel the DUT hands off.
// -----------------------------------------------------------------------------
module tb_axis_kernel_window_3x3;

  localparam int W = 5;
  localparam int H = 4;

  typedef logic [0:2][0:2][7:0] win_t;

  typedef struct {
    int         row;
    int         col;
    logic [7:0] e00;
    logic [7:0] e11;
    logic [7:0] e22;
  } vec_t;

  logic       clk;
  logic       i_reset;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic       s_axis_tuser;
  logic       s_axis_tlast;
  win_t       o_image_kernel_buffer;
  logic       o_kernel_valid;
  logic       i_kernel_ready;
  logic       o_line_err;

  int         testsRun;
  int         testsFailed;

  win_t       expQ[$];
  win_t       logQ[$];
  win_t       monExp;

  logic [7:0] img [H][W];
  bit         mActive;
  bit         mErr;
  int         mRow;
  int         mCol;

  vec_t       vecs [6];

  axis_kernel_window_3x3 #(
    .DATA_WIDTH (8),
    .KERNEL_SIZE(3),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .i_clk                (clk),
    .i_reset              (i_reset),
    .s_axis_tdata         (s_axis_tdata),
    .s_axis_tvalid        (s_axis_tvalid),
    .s_axis_tready        (s_axis_tready),
    .s_axis_tuser         (s_axis_tuser),
    .s_axis_tlast         (s_axis_tlast),
    .o_image_kernel_buffer(o_image_kernel_buffer),
    .o_kernel_valid       (o_kernel_valid),
    .i_kernel_ready       (i_kernel_ready),
    .o_line_err           (o_line_err)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something upstream of the bounded waits wedges.
  initial begin
    #200000;
    $display("[TB] FAIL global timeout: got no finish, expected finish");
    $fatal(1, "[TB] global timeout");
  end

  task automatic checkOutput(input string name, input logic [71:0] act,
                             input logic [71:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model for one accepted beat: tracks frame position, the
  // sticky tlast error, and queues the kernel any interior pixel completes.
  task automatic modelAccept(input logic [7:0] d, input logic u,
                             input logic l, output bit pushed);
    win_t w;
    pushed = 1'b0;
    if (!mActive && !u) return;
    if (u) begin
      mRow = 0;
      mCol = 0;
      mErr = 1'b0;
    end
    mActive = 1'b1;
    img[mRow][mCol] = d;
    if (l != (mCol == W - 1)) mErr = 1'b1;
    if (mRow >= 2 && mCol >= 2) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          w[i][j] = img[mRow - 2 + i][mCol - 2 + j];
      expQ.push_back(w);
      pushed = 1'b1;
    end
    if (mCol == W - 1) begin
      mCol = 0;
      if (mRow == H - 1) begin
        mRow    = 0;
        mActive = 1'b0;
      end else begin
        mRow++;
      end
    end else begin
      mCol++;
    end
  endtask

  // Presents one beat and holds it until the DUT takes it (bounded).
  task automatic applyStimulus(input logic [7:0] d, input logic u,
                               input logic l);
    bit done;
    bit pushed;
    int waited;
    done   = 1'b0;
    waited = 0;
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (s_axis_tready) begin
        modelAccept(d, u, l, pushed);
        @(posedge clk);
        #1;
        done = 1'b1;
        checkOutput("line_err after beat", 72'(o_line_err), 72'(mErr));
        if (pushed) begin
          checkOutput("valid one cycle after pixel", 72'(o_kernel_valid), 72'(1'b1));
          checkOutput("window[2][2] is new pixel",
                      72'(o_image_kernel_buffer[2][2]), 72'(d));
        end
      end else begin
        waited++;
        @(posedge clk);
        #1;
        if (waited > 200) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL beat accept timeout: got no tready, expected tready for %0h", d);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic sendFrame(input logic [7:0] base, input int badIdx,
                           input int lastIdx);
    int r;
    int c;
    for (int idx = 0; idx <= lastIdx; idx++) begin
      r = idx / W;
      c = idx % W;
      applyStimulus(base + 8'(r * 16 + c), idx == 0,
                    (c == W - 1) ^ (idx == badIdx));
    end
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkDrained();
    idle(4);
    checkOutput("scoreboard drained", 72'(expQ.size()), 72'(0));
    checkOutput("valid idle after frame", 72'(o_kernel_valid), 72'(1'b0));
  endtask

  task automatic checkTable(input string tag);
    checkOutput({tag, " window count"}, 72'(logQ.size()), 72'(6));
    for (int i = 0; i < 6 && i < logQ.size(); i++) begin
      checkOutput({tag, " [0][0]"}, 72'(logQ[i][0][0]), 72'(vecs[i].e00));
      checkOutput({tag, " [1][1]"}, 72'(logQ[i][1][1]), 72'(vecs[i].e11));
      checkOutput({tag, " [2][2]"}, 72'(logQ[i][2][2]), 72'(vecs[i].e22));
    end
  endtask

  // Scoreboard monitor: every handoff (valid && ready at the coming edge)
  // must match the oldest expected kernel.
  always @(negedge clk) begin
    if (!i_reset && o_kernel_valid && i_kernel_ready) begin
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected window: got %0h expected none",
                 o_image_kernel_buffer);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("window contents", 72'(o_image_kernel_buffer), 72'(monExp));
      end
      logQ.push_back(o_image_kernel_buffer);
    end
  end

  initial begin
    win_t snap;
    int   n;

    vecs[0] = '{row: 2, col: 2, e00: 8'h00, e11: 8'h11, e22: 8'h22};
    vecs[1] = '{row: 2, col: 3, e00: 8'h01, e11: 8'h12, e22: 8'h23};
    vecs[2] = '{row: 2, col: 4, e00: 8'h02, e11: 8'h13, e22: 8'h24};
    vecs[3] = '{row: 3, col: 2, e00: 8'h10, e11: 8'h21, e22: 8'h32};
    vecs[4] = '{row: 3, col: 3, e00: 8'h11, e11: 8'h22, e22: 8'h33};
    vecs[5] = '{row: 3, col: 4, e00: 8'h12, e11: 8'h23, e22: 8'h34};

    testsRun       = 0;
    testsFailed    = 0;
    mActive        = 1'b0;
    mErr           = 1'b0;
    mRow           = 0;
    mCol           = 0;
    i_reset        = 1'b1;
    i_kernel_ready = 1'b1;
    s_axis_tdata   = '0;
    s_axis_tvalid  = 1'b0;
    s_axis_tuser   = 1'b0;
    s_axis_tlast   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset valid", 72'(o_kernel_valid), 72'(1'b0));
    checkOutput("reset line_err", 72'(o_line_err), 72'(1'b0));
    checkOutput("reset window", 72'(o_image_kernel_buffer), 72'(0));
    checkOutput("reset tready", 72'(s_axis_tready), 72'(1'b0));
    i_reset = 1'b0;
    idle(2);

    $display("[TB] plain frame");
    logQ.delete();
    sendFrame(8'h00, -1, W * H - 1);
    checkDrained();
    checkTable("plain");
    checkOutput("plain line_err", 72'(o_line_err), 72'(1'b0));

    $display("[TB] downstream stall after first window");
    logQ.delete();
    fork
      sendFrame(8'h00, -1, W * H - 1);
      begin
        n = 0;
        while (!o_kernel_valid && n < 500) begin
          @(posedge clk);
          #1;
          n++;
        end
        checkOutput("stall saw first window", 72'(o_kernel_valid), 72'(1'b1));
        i_kernel_ready = 1'b0;
        snap = o_image_kernel_buffer;
        repeat (5) begin
          @(negedge clk);
          checkOutput("stall valid held", 72'(o_kernel_valid), 72'(1'b1));
          checkOutput("stall window stable", 72'(o_image_kernel_buffer), 72'(snap));
          checkOutput("stall tready low", 72'(s_axis_tready), 72'(1'b0));
        end
        @(posedge clk);
        #1;
        i_kernel_ready = 1'b1;
      end
    join
    checkDrained();
    checkTable("stall");

    $display("[TB] junk beats before start of frame");
    logQ.delete();
    applyStimulus(8'hAA, 1'b0, 1'b0);
    applyStimulus(8'hBB, 1'b0, 1'b0);
    idle(3);
    checkOutput("no window before sof", 72'(o_kernel_valid), 72'(1'b0));
    checkOutput("no log before sof", 72'(logQ.size()), 72'(0));
    sendFrame(8'h00, -1, W * H - 1);
    checkDrained();
    checkTable("pre-sof");

    $display("[TB] early tlast at (1,3)");
    logQ.delete();
    sendFrame(8'h00, 8, W * H - 1);
    checkDrained();
    checkOutput("line_err sticky", 72'(o_line_err), 72'(1'b1));
    sendFrame(8'h00, -1, W * H - 1);
    checkDrained();
    checkOutput("line_err cleared by sof", 72'(o_line_err), 72'(1'b0));
    logQ = logQ[6:$];
    checkTable("after-err");

    $display("[TB] reset mid-frame after (2,3)");
    logQ.delete();
    sendFrame(8'h00, 8, 13);
    i_reset       = 1'b1;
    s_axis_tvalid = 1'b0;
    checkOutput("one window pending at reset", 72'(expQ.size()), 72'(1));
    expQ.delete();
    mActive = 1'b0;
    mErr    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("mid reset valid", 72'(o_kernel_valid), 72'(1'b0));
    checkOutput("mid reset line_err", 72'(o_line_err), 72'(1'b0));
    checkOutput("mid reset window", 72'(o_image_kernel_buffer), 72'(0));
    i_reset = 1'b0;
    logQ.delete();
    idle(2);
    sendFrame(8'h00, -1, W * H - 1);
    checkDrained();
    checkTable("post-reset");

    $display("[TB] start of frame reasserted at (2,1)");
    logQ.delete();
    sendFrame(8'h00, -1, 10);
    sendFrame(8'h80, -1, W * H - 1);
    checkDrained();
    checkOutput("restart window count", 72'(logQ.size()), 72'(6));
    if (logQ.size() > 0) begin
      checkOutput("restart first [0][0]", 72'(logQ[0][0][0]), 72'(8'h80));
      checkOutput("restart first [2][2]", 72'(logQ[0][2][2]), 72'(8'hA2));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
